// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
// Per-scanline sprite scheduler. During horizontal blank it walks the sprite attribute
// table, collects up to SLOTS sprites that intersect the next scanline into a shadow slot
// set, and at the end of the line swaps that set into the active set. During active video
// it resolves which active sprite owns each pixel, with one Clk of latency.
//
// Ports:
//   Clk, Reset        pixel clock, synchronous active-high reset
//   DrawX, DrawY      current raster position (X 640..799 and Y 480..524 are blank)
//   attr_*            attribute table write port (entry, left edge, top edge, enable)
//   pix_valid/id/u/v  owning sprite and texel coordinate for the previous Clk's pixel
//   line_overflow     more than SLOTS sprites intersected the displayed line
//   scan_busy         high while the attribute table is being scanned
module sprite_line_scheduler #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  localparam int unsigned IdW        = $clog2(NUM_SPRITES),
  localparam int unsigned UW         = $clog2(SPRITE_W),
  localparam int unsigned VW         = $clog2(SPRITE_H)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [9:0]     DrawX,
  input  logic [9:0]     DrawY,
  input  logic           attr_we,
  input  logic [IdW-1:0] attr_addr,
  input  logic [9:0]     attr_x,
  input  logic [9:0]     attr_y,
  input  logic           attr_en,
  output logic           pix_valid,
  output logic [IdW-1:0] pix_id,
  output logic [UW-1:0]  pix_u,
  output logic [VW-1:0]  pix_v,
  output logic           line_overflow,
  output logic           scan_busy
);

  localparam int unsigned CntW = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  // Attribute table
  logic       tbl_en_q [NUM_SPRITES];
  logic [9:0] tbl_x_q  [NUM_SPRITES];
  logic [9:0] tbl_y_q  [NUM_SPRITES];

  state_e              state_q, state_d;
  logic [IdW-1:0]      idx_q, idx_d;
  logic [9:0]          ty_q, ty_d;
  logic [CntW-1:0]     sh_cnt_q, sh_cnt_d;
  logic                sh_ovf_q, sh_ovf_d;
  logic [SLOTS-1:0]    sh_valid_q, sh_valid_d, act_valid_q, act_valid_d;
  logic [SLOTS-1:0][IdW-1:0] sh_id_q, sh_id_d, act_id_q, act_id_d;
  logic [SLOTS-1:0][9:0]     sh_x_q, sh_x_d, act_x_q, act_x_d;
  logic [SLOTS-1:0][VW-1:0]  sh_v_q, sh_v_d, act_v_q, act_v_d;
  logic                line_ovf_q, line_ovf_d;

  logic [9:0]          dy;
  logic [SLOTS-1:0][9:0] dx;
  logic                hit;
  logic [IdW-1:0]      hit_id;
  logic [UW-1:0]       hit_u;
  logic [VW-1:0]       hit_v;

  logic                pix_valid_q;
  logic [IdW-1:0]      pix_id_q;
  logic [UW-1:0]       pix_u_q;
  logic [VW-1:0]       pix_v_q;

  // Scan reads registered table state, so a same-cycle write is seen one cycle later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        tbl_en_q[i] <= 1'b0;
        tbl_x_q[i]  <= '0;
        tbl_y_q[i]  <= '0;
      end
    end else if (attr_we) begin
      tbl_en_q[attr_addr] <= attr_en;
      tbl_x_q[attr_addr]  <= attr_x;
      tbl_y_q[attr_addr]  <= attr_y;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ty_d        = ty_q;
    sh_cnt_d    = sh_cnt_q;
    sh_ovf_d    = sh_ovf_q;
    sh_valid_d  = sh_valid_q;
    sh_id_d     = sh_id_q;
    sh_x_d      = sh_x_q;
    sh_v_d      = sh_v_q;
    act_valid_d = act_valid_q;
    act_id_d    = act_id_q;
    act_x_d     = act_x_q;
    act_v_d     = act_v_q;
    line_ovf_d  = line_ovf_q;
    // Modular row offset; y near 1023 deliberately wraps into the top rows.
    dy          = ty_q - tbl_y_q[idx_q];

    case (state_q)
      StIdle: begin
        if (DrawX == 10'd640) begin
          state_d    = StScan;
          idx_d      = '0;
          ty_d       = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
          sh_cnt_d   = '0;
          sh_ovf_d   = 1'b0;
          sh_valid_d = '0;
        end
      end
      StScan: begin
        if (tbl_en_q[idx_q] && (dy < 10'(SPRITE_H))) begin
          if (sh_cnt_q < CntW'(SLOTS)) begin
            // Slots fill in order, so the count is the lowest free slot.
            for (int s = 0; s < int'(SLOTS); s++) begin
              if (sh_cnt_q == CntW'(s)) begin
                sh_valid_d[s] = 1'b1;
                sh_id_d[s]    = idx_q;
                sh_x_d[s]     = tbl_x_q[idx_q];
                sh_v_d[s]     = dy[VW-1:0];
              end
            end
            sh_cnt_d = sh_cnt_q + CntW'(1);
          end else begin
            sh_ovf_d = 1'b1;
          end
        end
        if (idx_q == IdW'(NUM_SPRITES - 1)) begin
          state_d = StHold;
        end else begin
          idx_d = idx_q + IdW'(1);
        end
      end
      StHold: begin
        if (DrawX == 10'd799) begin
          act_valid_d = sh_valid_q;
          act_id_d    = sh_id_q;
          act_x_d     = sh_x_q;
          act_v_d     = sh_v_q;
          line_ovf_d  = sh_ovf_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      ty_q        <= '0;
      sh_cnt_q    <= '0;
      sh_ovf_q    <= 1'b0;
      sh_valid_q  <= '0;
      sh_id_q     <= '0;
      sh_x_q      <= '0;
      sh_v_q      <= '0;
      act_valid_q <= '0;
      act_id_q    <= '0;
      act_x_q     <= '0;
      act_v_q     <= '0;
      line_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ty_q        <= ty_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_ovf_q    <= sh_ovf_d;
      sh_valid_q  <= sh_valid_d;
      sh_id_q     <= sh_id_d;
      sh_x_q      <= sh_x_d;
      sh_v_q      <= sh_v_d;
      act_valid_q <= act_valid_d;
      act_id_q    <= act_id_d;
      act_x_q     <= act_x_d;
      act_v_q     <= act_v_d;
      line_ovf_q  <= line_ovf_d;
    end
  end

  // Pixel resolve: scan slots high to low so the lowest-index hit is the one left standing.
  always_comb begin
    dx     = '0;
    hit    = 1'b0;
    hit_id = '0;
    hit_u  = '0;
    hit_v  = '0;
    for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
      dx[s] = DrawX - act_x_q[s];
      if (act_valid_q[s] && (dx[s] < 10'(SPRITE_W))) begin
        hit    = 1'b1;
        hit_id = act_id_q[s];
        hit_u  = dx[s][UW-1:0];
        hit_v  = act_v_q[s];
      end
    end
    if ((DrawX >= 10'd640) || (DrawY >= 10'd480)) begin
      hit    = 1'b0;
      hit_id = '0;
      hit_u  = '0;
      hit_v  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_valid_q <= 1'b0;
      pix_id_q    <= '0;
      pix_u_q     <= '0;
      pix_v_q     <= '0;
    end else begin
      pix_valid_q <= hit;
      pix_id_q    <= hit_id;
      pix_u_q     <= hit_u;
      pix_v_q     <= hit_v;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign pix_id        = pix_id_q;
  assign pix_u         = pix_u_q;
  assign pix_v         = pix_v_q;
  assign line_overflow = line_ovf_q;
  assign scan_busy     = (state_q == StScan);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Testbench for sprite_line_scheduler. Raster position is driven directly; each line
// visits a subset of visible columns, then X=640..660 and X=799 so every scan and
// active-set swap occurs. Expected outputs come from a line-level reference model.
module tb_sprite_line_scheduler;

  localparam int NS = 8;
  localparam int SL = 4;
  localparam int SW = 16;
  localparam int SH = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       attr_we = 1'b0;
  logic [2:0] attr_addr = '0;
  logic [9:0] attr_x = '0;
  logic [9:0] attr_y = '0;
  logic       attr_en = 1'b0;
  logic       pix_valid;
  logic [2:0] pix_id;
  logic [3:0] pix_u;
  logic [3:0] pix_v;
  logic       line_overflow;
  logic       scan_busy;

  always #5 Clk = ~Clk;

  sprite_line_scheduler #(
    .NUM_SPRITES(NS),
    .SLOTS      (SL),
    .SPRITE_W   (SW),
    .SPRITE_H   (SH)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .attr_we      (attr_we),
    .attr_addr    (attr_addr),
    .attr_x       (attr_x),
    .attr_y       (attr_y),
    .attr_en      (attr_en),
    .pix_valid    (pix_valid),
    .pix_id       (pix_id),
    .pix_u        (pix_u),
    .pix_v        (pix_v),
    .line_overflow(line_overflow),
    .scan_busy    (scan_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [13:0] dut_vec;
  assign dut_vec = {pix_valid, pix_id, pix_u, pix_v, line_overflow, scan_busy};

  // Reference model: table, per-entry snapshot taken when the scan reads it, and the
  // ordered list of sprites displayed on the current line.
  int   m_en[NS], m_x[NS], m_y[NS];
  int   s_en[NS], s_x[NS], s_y[NS];
  int   a_n = 0;
  int   a_id[SL], a_x[SL], a_v[SL];
  bit   a_ovf = 1'b0;
  bit   sc_on = 1'b0;
  int   sc_k = 0;
  int   sc_ty = 0;
  logic e_valid;
  logic [2:0] e_id;
  logic [3:0] e_u, e_v;
  logic [13:0] exp_vec;
  int   xs[$];

  // Effect of the coming clock edge given the inputs now applied.
  task automatic model_edge();
    int  dx;
    int  d;
    bit  found;
    if (Reset) begin
      for (int i = 0; i < NS; i++) begin
        m_en[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      a_n = 0; a_ovf = 1'b0; sc_on = 1'b0; sc_k = 0;
      e_valid = 1'b0; e_id = '0; e_u = '0; e_v = '0;
    end else begin
      found = 1'b0;
      e_valid = 1'b0; e_id = '0; e_u = '0; e_v = '0;
      if (DrawX < 640 && DrawY < 480) begin
        for (int s = 0; s < a_n; s++) begin
          dx = (int'(DrawX) - a_x[s]) & 1023;
          if (!found && dx < SW) begin
            found = 1'b1;
            e_valid = 1'b1; e_id = 3'(a_id[s]); e_u = 4'(dx); e_v = 4'(a_v[s]);
          end
        end
      end
      if (sc_on) begin
        if (sc_k < NS) begin
          s_en[sc_k] = m_en[sc_k]; s_x[sc_k] = m_x[sc_k]; s_y[sc_k] = m_y[sc_k];
          sc_k++;
        end else if (DrawX == 799) begin
          a_n = 0; a_ovf = 1'b0;
          for (int i = 0; i < NS; i++) begin
            d = (sc_ty - s_y[i]) & 1023;
            if (s_en[i] != 0 && d < SH) begin
              if (a_n < SL) begin
                a_id[a_n] = i; a_x[a_n] = s_x[i]; a_v[a_n] = d; a_n++;
              end else begin
                a_ovf = 1'b1;
              end
            end
          end
          sc_on = 1'b0;
        end
      end else if (DrawX == 640) begin
        sc_on = 1'b1; sc_k = 0;
        sc_ty = (DrawY == 524) ? 0 : int'(DrawY) + 1;
      end
      if (attr_we) begin
        m_en[attr_addr] = int'(attr_en); m_x[attr_addr] = int'(attr_x);
        m_y[attr_addr] = int'(attr_y);
      end
    end
    exp_vec = {e_valid, e_id, e_u, e_v, a_ovf, (sc_on && sc_k < NS)};
  endtask

  task automatic step(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    model_edge();
    @(posedge Clk);
    #1;
    attr_we = 1'b0;
  endtask

  task automatic do_reset(input int y);
    Reset = 1'b1;
    step(700, y);
    Reset = 1'b0;
  endtask

  task automatic wr(input int id, input int x, input int y, input bit en);
    attr_addr = 3'(id); attr_x = 10'(x); attr_y = 10'(y); attr_en = en; attr_we = 1'b1;
    step(700, int'(DrawY));
  endtask

  function automatic void build_xs(input int nrand);
    xs.delete();
    repeat (nrand) xs.push_back(int'($urandom_range(0, 639)));
  endfunction

  function automatic void add_blank();
    for (int x = 640; x <= 660; x++) xs.push_back(x);
    xs.push_back(799);
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    step(700, 0);
    step(700, 0);
    n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_pix_valid got=%b want=0", pix_valid); end
    n_cmp++; if (pix_id !== 3'd0) begin n_err++; $display("FAIL reset_pix_id got=%0d want=0", pix_id); end
    n_cmp++; if (pix_u !== 4'd0) begin n_err++; $display("FAIL reset_pix_u got=%0d want=0", pix_u); end
    n_cmp++; if (pix_v !== 4'd0) begin n_err++; $display("FAIL reset_pix_v got=%0d want=0", pix_v); end
    n_cmp++; if (line_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", line_overflow); end
    n_cmp++; if (scan_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", scan_busy); end
    Reset = 1'b0;
    step(640, 0);
    n_cmp++; if (scan_busy !== 1'b1) begin n_err++; $display("FAIL reset_scan_start got=%b want=1", scan_busy); end
  endtask

  task automatic test_empty_frame();
    int busy;
    do_reset(524);
    for (int yy = 0; yy <= 524; yy++) begin
      build_xs(4); add_blank();
      busy = 0;
      foreach (xs[k]) begin
        step(xs[k], yy);
        if (scan_busy === 1'b1) busy++;
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL frame_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
      end
      n_cmp++;
      if (busy != NS) begin n_err++; $display("FAIL frame_busy_len y=%0d got=%0d want=%0d", yy, busy, NS); end
    end
  endtask

  task automatic test_single();
    do_reset(46);
    wr(2, 100, 50, 1'b1);
    for (int yy = 47; yy <= 67; yy++) begin
      build_xs(8);
      xs.push_back(99); xs.push_back(100); xs.push_back(107); xs.push_back(115); xs.push_back(116);
      add_blank();
      foreach (xs[k]) begin
        step(xs[k], yy);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL single_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
        if (xs[k] == 107 && yy == 53) begin
          n_cmp++;
          if ({pix_valid, pix_id, pix_u, pix_v} !== {1'b1, 3'd2, 4'd7, 4'd3}) begin
            n_err++; $display("FAIL single_texel got=%h want=%h", {pix_valid, pix_id, pix_u, pix_v}, {1'b1, 3'd2, 4'd7, 4'd3});
          end
        end
        if (((xs[k] == 99 || xs[k] == 116) && yy == 50) || (xs[k] == 100 && (yy == 49 || yy == 66))) begin
          n_cmp++;
          if (pix_valid !== 1'b0) begin n_err++; $display("FAIL single_edge x=%0d y=%0d got=%b want=0", xs[k], yy, pix_valid); end
        end
        if ((xs[k] == 100 || xs[k] == 115) && (yy == 50 || yy == 65)) begin
          n_cmp++;
          if ({pix_valid, pix_id} !== {1'b1, 3'd2}) begin
            n_err++; $display("FAIL single_inside x=%0d y=%0d got=%h want=%h", xs[k], yy, {pix_valid, pix_id}, {1'b1, 3'd2});
          end
        end
      end
    end
  endtask

  task automatic test_overlap();
    logic [3:0] want;
    do_reset(48);
    wr(1, 100, 50, 1'b1);
    wr(5, 108, 50, 1'b1);
    for (int yy = 49; yy <= 51; yy++) begin
      build_xs(4);
      for (int x = 106; x <= 125; x++) xs.push_back(x);
      add_blank();
      foreach (xs[k]) begin
        step(xs[k], yy);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL overlap_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
        if (yy == 50 && xs[k] >= 108 && xs[k] <= 123) begin
          want = (xs[k] <= 115) ? {1'b1, 3'd1} : {1'b1, 3'd5};
          n_cmp++;
          if ({pix_valid, pix_id} !== want) begin
            n_err++; $display("FAIL overlap_owner x=%0d got=%h want=%h", xs[k], {pix_valid, pix_id}, want);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(197);
    for (int i = 0; i < 6; i++) wr(i, 40 * i, 200, 1'b1);
    for (int yy = 198; yy <= 217; yy++) begin
      build_xs(6);
      xs.push_back(45); xs.push_back(125); xs.push_back(165); xs.push_back(205);
      add_blank();
      foreach (xs[k]) begin
        step(xs[k], yy);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL overflow_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
        if (yy == 200 && xs[k] == 45) begin
          n_cmp++;
          if ({pix_valid, pix_id, line_overflow} !== {1'b1, 3'd1, 1'b1}) begin
            n_err++; $display("FAIL overflow_kept got=%h want=%h", {pix_valid, pix_id, line_overflow}, {1'b1, 3'd1, 1'b1});
          end
        end
        if (yy == 200 && (xs[k] == 165 || xs[k] == 205)) begin
          n_cmp++;
          if (pix_valid !== 1'b0) begin n_err++; $display("FAIL overflow_dropped x=%0d got=%b want=0", xs[k], pix_valid); end
        end
        if (yy == 216 && xs[k] == 45) begin
          n_cmp++;
          if (line_overflow !== 1'b0) begin n_err++; $display("FAIL overflow_clear got=%b want=0", line_overflow); end
        end
      end
    end
  endtask

  task automatic test_edges();
    int yy;
    do_reset(522);
    wr(0, 0, 0, 1'b1);
    wr(3, 630, 10, 1'b1);
    yy = 523;
    for (int n = 0; n < 14; n++) begin
      build_xs(4);
      xs.push_back(0); xs.push_back(15); xs.push_back(16);
      xs.push_back(629); xs.push_back(630); xs.push_back(639);
      add_blank();
      foreach (xs[k]) begin
        step(xs[k], yy);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL edges_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
        if (yy == 0 && xs[k] == 0) begin
          n_cmp++;
          if ({pix_valid, pix_id, pix_u, pix_v} !== 12'h800) begin
            n_err++; $display("FAIL edges_origin got=%h want=800", {pix_valid, pix_id, pix_u, pix_v});
          end
        end
        if (yy == 10 && xs[k] == 639) begin
          n_cmp++;
          if ({pix_valid, pix_id, pix_u, pix_v} !== {1'b1, 3'd3, 4'd9, 4'd0}) begin
            n_err++; $display("FAIL edges_right got=%h want=%h", {pix_valid, pix_id, pix_u, pix_v}, {1'b1, 3'd3, 4'd9, 4'd0});
          end
        end
        if (yy == 10 && xs[k] == 629) begin
          n_cmp++;
          if (pix_valid !== 1'b0) begin n_err++; $display("FAIL edges_left_of_right got=%b want=0", pix_valid); end
        end
      end
      yy = (yy == 524) ? 0 : yy + 1;
    end
  endtask

  task automatic test_midscan();
    do_reset(58);
    wr(2, 100, 50, 1'b1);
    wr(6, 400, 65, 1'b1);
    for (int yy = 59; yy <= 72; yy++) begin
      xs.delete();
      xs.push_back(100); xs.push_back(105); xs.push_back(116); xs.push_back(299);
      xs.push_back(300); xs.push_back(301); xs.push_back(400); xs.push_back(405);
      xs.push_back(415); xs.push_back(500);
      add_blank();
      foreach (xs[k]) begin
        if (yy == 60 && xs[k] == 645) begin
          n_cmp++;
          if (scan_busy !== 1'b1) begin n_err++; $display("FAIL midscan_busy got=%b want=1", scan_busy); end
          attr_addr = 3'd2; attr_x = 10'd100; attr_y = 10'd300; attr_en = 1'b1; attr_we = 1'b1;
        end
        if (yy == 70 && xs[k] == 300) Reset = 1'b1;
        step(xs[k], yy);
        Reset = 1'b0;
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL midscan_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
        if (yy == 61 && xs[k] == 105) begin
          n_cmp++;
          if ({pix_valid, pix_id, pix_v} !== {1'b1, 3'd2, 4'd11}) begin
            n_err++; $display("FAIL midscan_old_line got=%h want=%h", {pix_valid, pix_id, pix_v}, {1'b1, 3'd2, 4'd11});
          end
        end
        if (yy == 62 && xs[k] == 105) begin
          n_cmp++;
          if (pix_valid !== 1'b0) begin n_err++; $display("FAIL midscan_moved got=%b want=0", pix_valid); end
        end
        if (yy == 69 && xs[k] == 405) begin
          n_cmp++;
          if ({pix_valid, pix_id} !== {1'b1, 3'd6}) begin
            n_err++; $display("FAIL midscan_pre_reset got=%h want=%h", {pix_valid, pix_id}, {1'b1, 3'd6});
          end
        end
        if (((yy == 70 && xs[k] >= 300) || yy == 71) && xs[k] < 640) begin
          n_cmp++;
          if (pix_valid !== 1'b0) begin n_err++; $display("FAIL midscan_post_reset x=%0d y=%0d got=%b want=0", xs[k], yy, pix_valid); end
        end
      end
    end
  endtask

  task automatic test_random();
    int yy;
    int y0;
    y0 = int'($urandom_range(0, 520));
    do_reset(y0);
    for (int i = 0; i < NS; i++)
      wr(i, int'($urandom_range(0, 1023)), (y0 + int'($urandom_range(0, 70))) & 1023, 1'($urandom_range(0, 3) != 0));
    yy = (y0 == 524) ? 0 : y0 + 1;
    for (int n = 0; n < 60; n++) begin
      build_xs(24); add_blank();
      foreach (xs[k]) begin
        if ($urandom_range(0, 15) == 0) begin
          attr_addr = 3'($urandom_range(0, NS - 1));
          attr_x    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 650));
          attr_y    = 10'((y0 + int'($urandom_range(0, 70))) & 1023);
          attr_en   = 1'($urandom_range(0, 3) != 0);
          attr_we   = 1'b1;
        end
        step(xs[k], yy);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL random_vec x=%0d y=%0d got=%h want=%h", xs[k], yy, dut_vec, exp_vec);
        end
      end
      yy = (yy == 524) ? 0 : yy + 1;
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_single();
    test_overlap();
    test_overflow();
    test_edges();
    test_midscan();
    test_random();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline sprite scheduler that shares the pixel colour path between up to NUM_SPRITES sprite requesters. During each horizontal blank it scans a sprite attribute table, selects up to SLOTS sprites that intersect the next scanline, and loads them into an active slot set. During active video it resolves priority per pixel and tells the colour mapper which sprite, if any, owns the pixel, plus the texel coordinate inside that sprite. It sits between the game/frame logic, which writes the attributes, and the colour mapper.

## Interface
- NUM_SPRITES, 8, attribute table entries; power of two, at least 2
- SLOTS, 4, maximum sprites shown per scanline; 1 to NUM_SPRITES
- SPRITE_W, 16, sprite width in pixels; power of two
- SPRITE_H, 16, sprite height in pixels; power of two

Ports:
- Clk  in  1  pixel clock; DrawX/DrawY advance one pixel per Clk
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column, 0..799 (640..799 is horizontal blank)
- DrawY  in  10  current pixel row, 0..524 (480..524 is vertical blank)
- attr_we  in  1  attribute write strobe
- attr_addr  in  log2(NUM_SPRITES)  entry to write
- attr_x  in  10  sprite left edge
- attr_y  in  10  sprite top edge
- attr_en  in  1  sprite enable
- pix_valid  out  1  a sprite owns the pixel
- pix_id  out  log2(NUM_SPRITES)  owning sprite index
- pix_u  out  log2(SPRITE_W)  column inside sprite
- pix_v  out  log2(SPRITE_H)  row inside sprite
- line_overflow  out  1  more than SLOTS sprites hit the displayed line
- scan_busy  out  1  scan in progress

## Operation
- Attribute table: written on any cycle with attr_we=1, effective the next cycle. A scan read of the entry written in the same cycle returns the old value. Writes to an already-scanned entry take effect on the following line.
- FSM states: IDLE, SCAN, HOLD.
  - IDLE to SCAN: on the cycle DrawX==640. Target line Y' = (DrawY==524) ? 0 : DrawY+1. Clear the shadow slot set and the candidate count.
  - SCAN: examine entry i = 0..NUM_SPRITES-1, one per cycle, in ascending order. Candidate when en=1 and (Y' − y) mod 1024 < SPRITE_H, using 10-bit unsigned subtraction.
    - While the shadow set has a free slot, load {id=i, x, v=(Y'−y)[low bits]} into the lowest free slot.
    - A candidate found when all slots are full sets the shadow overflow flag. Extra sprites are dropped.
    - After entry NUM_SPRITES−1, go to HOLD.
  - HOLD: on the cycle DrawX==799, copy the shadow set and shadow overflow into the active set and line_overflow, then go to IDLE.
- Pixel resolve, registered, 1 Clk latency:
  - Slot s hits when it is valid and (DrawX − x_s) mod 1024 < SPRITE_W.
  - Output qualified by DrawX<640 and DrawY<480.
  - The lowest-index hitting slot wins. Because slots fill in id order, the lowest sprite id wins.
  - pix_u = (DrawX − x_s) low bits; pix_v = the stored v.
  - No hit: pix_valid=0, and pix_id, pix_u and pix_v are all 0.
- scan_busy=1 exactly while in SCAN.
- Sprites partly off the right edge are clipped by the DrawX<640 gate. Sprites with y near 1023 wrap into the top rows by the modular compare; this behaviour is intentional.

## Timing
- Reset, synchronous:
  - All table entries: en=0, x=0, y=0.
  - Shadow and active slots invalid.
  - FSM in IDLE.
  - pix_valid, pix_id, pix_u, pix_v, line_overflow and scan_busy all 0.
- Reset mid-line or mid-scan: the line in progress and the next line show no sprites. Normal scanning resumes at the next DrawX==640.
- SCAN lasts NUM_SPRITES cycles starting the cycle after DrawX==640. NUM_SPRITES + 1 ≤ 159 is required so the scan finishes before DrawX==799.
- Output for pixel (X,Y) appears the Clk after DrawX==X. The colour mapper delays its own coordinates by one cycle.
- The active set changes only at the DrawX==799 edge, so it is stable for the whole visible line.

## Test plan
- Reset, no writes, run one full frame -> pix_valid=0, line_overflow=0 everywhere; scan_busy high for 8 cycles on every line.
- Sprite 2 at (100,50), en=1 -> pix_valid=1, pix_id=2 for X=100..115, Y=50..65; at (107,53) pix_u=7, pix_v=3; pix_valid=0 at X=99, X=116, Y=49, Y=66.
- Sprites 1 at (100,50) and 5 at (108,50) -> X=108..115 reports pix_id=1; X=116..123 reports pix_id=5.
- Sprites 0..5 all at y=200, x=0,40,..,200 -> on Y=200 only ids 0..3 are drawn, ids 4 and 5 give pix_valid=0, line_overflow=1; at Y=216 line_overflow=0.
- Sprite at (0,0) -> scan during the DrawY=524 blank; pix_valid=1 the Clk after DrawX=0, DrawY=0. Sprite at (630,10) -> visible only for X=630..639.
- Move sprite 2 from y=50 to y=300 via attr_we while scan_busy=1 at DrawY=60, after entry 2 has been scanned -> line 61 still shows sprite 2; line 62 does not. Assert Reset at DrawY=70, X=300 -> pix_valid=0 for the rest of line 70 and all of line 71.
